// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Holds opcode/funct values, ALU operation codes, the FSM state encoding
// and the datapath mux select codes driven by the controller.
package cu_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes; zero-extended to ALUOP_W at the top level
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_NOR = 3'd5;
    localparam logic [2:0] ALU_XOR = 3'd6;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU = 2'b00;
    localparam logic [1:0] PCSRC_OUT = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_R     = 4'd8,
        S_WB_I     = 4'd9,
        S_WB_MEM   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

endpackage

// File: rtl/cu_alu_decode.sv
// Combinational instruction decode for the multi-cycle controller.
// Ports:
//   opCode, funct : instruction fields from the IR
//   alu_op        : ALU operation for R-type (from funct) or I-ALU (from opcode)
//   ext_zero      : zero-extend the immediate (logical immediates)
//   legal         : instruction is one the controller knows how to sequence
module cu_alu_decode
    import cu_pkg::*;
(
    input  logic [5:0] opCode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       ext_zero,
    output logic       legal
);

    always_comb begin
        alu_op   = ALU_ADD;
        ext_zero = 1'b0;
        legal    = 1'b1;
        case (opCode)
            OP_R: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_XOR:  alu_op = ALU_XOR;
                    default: legal  = 1'b0;
                endcase
            end
            OP_ADDI: alu_op = ALU_ADD;
            OP_SLTI: alu_op = ALU_SLT;
            OP_ANDI: begin alu_op = ALU_AND; ext_zero = 1'b1; end
            OP_ORI:  begin alu_op = ALU_OR;  ext_zero = 1'b1; end
            OP_XORI: begin alu_op = ALU_XOR; ext_zero = 1'b1; end
            // Memory, branch and jump are legal; their ALU op is fixed by state
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: alu_op = ALU_ADD;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing FETCH/DECODE/EXECUTE/
// MEMORY/WRITEBACK and driving datapath enables every cycle.
// Ports:
//   clk, rst          : clock (rising edge), synchronous active-low reset
//   opCode, funct     : IR fields, stable from DECODE to end of instruction
//   zero              : ALU zero flag (used in BRANCH)
//   mem_ready         : memory access completes this cycle
//   pc_write..alu_op  : datapath enables and mux selects
//   illegal           : pulse in DECODE for an undefined instruction
//   instr_done        : pulse in each instruction's final state
//   state_dbg         : current state encoding
module multicycle_control_fsm
    import cu_pkg::*;
#(
    parameter int ALUOP_W       = 4,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opCode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_read_en,
    output logic               mem_write_en,
    output logic               reg_write_en,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               ext_zero,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal,
    output logic               instr_done,
    output logic [3:0]         state_dbg
);

    state_t     state, nxt;
    logic [2:0] dec_op;
    logic [2:0] aop;
    logic       dec_ext;
    logic       dec_legal;
    logic       rdy;

    cu_alu_decode u_dec (
        .opCode   (opCode),
        .funct    (funct),
        .alu_op   (dec_op),
        .ext_zero (dec_ext),
        .legal    (dec_legal)
    );

    // Without a handshake every memory access is single-cycle
    assign rdy       = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign alu_op    = ALUOP_W'(aop);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt          = S_IDLE;
        pc_write     = 1'b0;
        pc_src       = PCSRC_ALU;
        ir_write     = 1'b0;
        i_or_d       = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        reg_write_en = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_RT;
        ext_zero     = 1'b0;
        aop          = ALU_ADD;
        illegal      = 1'b0;
        instr_done   = 1'b0;
        case (state)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                mem_read_en = 1'b1;
                alu_src_b   = SRCB_FOUR;
                if (rdy) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = S_DECODE;
                end else begin
                    nxt = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut
                alu_src_b = SRCB_BOFF;
                if (!dec_legal) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                    nxt        = S_FETCH;
                end else begin
                    case (opCode)
                        OP_R:          nxt = S_EXEC_R;
                        OP_LW, OP_SW:  nxt = S_MEM_ADDR;
                        OP_BEQ,OP_BNE: nxt = S_BRANCH;
                        OP_J:          nxt = S_JUMP;
                        default:       nxt = S_EXEC_I; // remaining legal ops are I-ALU
                    endcase
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                aop       = dec_op;
                nxt       = S_WB_R;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                aop       = dec_op;
                ext_zero  = dec_ext;
                nxt       = S_WB_I;
            end
            S_WB_R: begin
                reg_write_en = 1'b1;
                reg_dst      = 1'b1;
                aop          = dec_op;
                instr_done   = 1'b1;
                nxt          = S_FETCH;
            end
            S_WB_I: begin
                reg_write_en = 1'b1;
                instr_done   = 1'b1;
                nxt          = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                nxt       = (opCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                i_or_d      = 1'b1;
                mem_read_en = 1'b1;
                nxt         = rdy ? S_WB_MEM : S_MEM_RD;
            end
            S_MEM_WR: begin
                i_or_d       = 1'b1;
                mem_write_en = 1'b1;
                instr_done   = rdy;
                nxt          = rdy ? S_FETCH : S_MEM_WR;
            end
            S_WB_MEM: begin
                reg_write_en = 1'b1;
                mem_to_reg   = 1'b1;
                instr_done   = 1'b1;
                nxt          = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                aop        = ALU_SUB;
                pc_src     = PCSRC_OUT;
                pc_write   = zero ^ (opCode == OP_BNE);
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = PCSRC_JMP;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            default: nxt = S_IDLE; // unused encodings recover through IDLE
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opCode, funct;
    logic       zero, mem_ready;
    logic       pc_write, ir_write, i_or_d, mem_read_en, mem_write_en;
    logic       reg_write_en, reg_dst, mem_to_reg, alu_src_a, ext_zero;
    logic       illegal, instr_done;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_op, state_dbg;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.ALUOP_W(4), .MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .rst(rst), .opCode(opCode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .reg_write_en(reg_write_en),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_op(alu_op),
        .illegal(illegal), .instr_done(instr_done), .state_dbg(state_dbg)
    );

    typedef struct packed {
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       iod;
        logic       mrd;
        logic       mwr;
        logic       rwe;
        logic       rdst;
        logic       m2r;
        logic       asa;
        logic [1:0] asb;
        logic       ext;
        logic [3:0] aop;
        logic       ill;
        logic       done;
    } outs_t;

    // One expected cycle: inputs to drive plus expected state/outputs
    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        outs_t      o;
    } rec_t;

    rec_t q[$];
    int total = 0;
    int bad   = 0;

    function automatic outs_t observed();
        outs_t ob;
        ob = '{pc_write, pc_src, ir_write, i_or_d, mem_read_en, mem_write_en,
               reg_write_en, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               ext_zero, alu_op, illegal, instr_done};
        return ob;
    endfunction

    // Reference tables straight from the instruction set definition
    function automatic int r_alu(logic [5:0] fn);
        case (fn)
            6'h20: return 0;  6'h22: return 1;  6'h24: return 2;
            6'h25: return 3;  6'h2A: return 4;  6'h27: return 5;
            6'h26: return 6;  default: return -1;
        endcase
    endfunction

    function automatic int i_alu(logic [5:0] op);
        case (op)
            6'h08: return 0;  6'h0A: return 4;  6'h0C: return 2;
            6'h0D: return 3;  6'h0E: return 6;  default: return -1;
        endcase
    endfunction

    function automatic rec_t blank(logic [3:0] st, logic [5:0] op, logic [5:0] fn, logic z);
        rec_t r;
        r.st = st; r.op = op; r.fn = fn; r.z = z;
        r.mr = 1'($urandom_range(0, 1));
        r.o  = '0;
        return r;
    endfunction

    // Expand one instruction into its expected per-cycle trace
    function automatic void build(logic [5:0] op, logic [5:0] fn, logic z, int wf, int wm);
        rec_t r;
        int   a;
        bit   legal;
        for (int i = 0; i <= wf; i++) begin
            r = blank(4'd1, 6'($urandom), 6'($urandom), 1'($urandom));
            r.mr = (i == wf);
            r.o.mrd = 1'b1; r.o.asb = 2'b01;
            r.o.irw = (i == wf); r.o.pcw = (i == wf);
            q.push_back(r);
        end
        if (op == 6'h00) legal = (r_alu(fn) >= 0);
        else legal = (i_alu(op) >= 0) || (op inside {6'h23, 6'h2B, 6'h04, 6'h05, 6'h02});
        r = blank(4'd2, op, fn, z);
        r.o.asb = 2'b11;
        if (!legal) begin
            r.o.ill = 1'b1; r.o.done = 1'b1;
            q.push_back(r);
            return;
        end
        q.push_back(r);
        if (op == 6'h00) begin
            a = r_alu(fn);
            r = blank(4'd3, op, fn, z); r.o.asa = 1'b1; r.o.aop = 4'(a); q.push_back(r);
            r = blank(4'd8, op, fn, z); r.o.rwe = 1'b1; r.o.rdst = 1'b1;
            r.o.aop = 4'(a); r.o.done = 1'b1; q.push_back(r);
        end else if (i_alu(op) >= 0) begin
            r = blank(4'd4, op, fn, z); r.o.asa = 1'b1; r.o.asb = 2'b10;
            r.o.aop = 4'(i_alu(op)); r.o.ext = op inside {6'h0C, 6'h0D, 6'h0E};
            q.push_back(r);
            r = blank(4'd9, op, fn, z); r.o.rwe = 1'b1; r.o.done = 1'b1; q.push_back(r);
        end else if (op == 6'h23 || op == 6'h2B) begin
            r = blank(4'd5, op, fn, z); r.o.asa = 1'b1; r.o.asb = 2'b10; q.push_back(r);
            for (int i = 0; i <= wm; i++) begin
                r = blank((op == 6'h23) ? 4'd6 : 4'd7, op, fn, z);
                r.mr = (i == wm); r.o.iod = 1'b1;
                if (op == 6'h23) r.o.mrd = 1'b1;
                else begin r.o.mwr = 1'b1; r.o.done = (i == wm); end
                q.push_back(r);
            end
            if (op == 6'h23) begin
                r = blank(4'd10, op, fn, z); r.o.rwe = 1'b1; r.o.m2r = 1'b1;
                r.o.done = 1'b1; q.push_back(r);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            r = blank(4'd11, op, fn, z); r.o.asa = 1'b1; r.o.aop = 4'd1; r.o.pcs = 2'b01;
            r.o.pcw = z ^ (op == 6'h05); r.o.done = 1'b1; q.push_back(r);
        end else begin
            r = blank(4'd12, op, fn, z); r.o.pcw = 1'b1; r.o.pcs = 2'b10;
            r.o.done = 1'b1; q.push_back(r);
        end
    endfunction

    // Drive the queued trace one cycle at a time and check every cycle
    task automatic play(input string tag, output int done_cyc);
        rec_t  r;
        outs_t ob;
        int    n = 0;
        done_cyc = -1;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk);
            opCode = r.op; funct = r.fn; zero = r.z; mem_ready = r.mr;
            #1;
            ob = observed();
            total++;
            if (state_dbg !== r.st) begin
                bad++;
                $display("FAIL %s cyc%0d state got=%0d want=%0d", tag, n, state_dbg, r.st);
            end
            total++;
            if (ob !== r.o) begin
                bad++;
                $display("FAIL %s cyc%0d st=%0d outs got=%h want=%h", tag, n, r.st, ob, r.o);
            end
            if (instr_done === 1'b1 && done_cyc < 0) done_cyc = n + 1;
            n++;
        end
    endtask

    task automatic test_reset();
        outs_t ob;
        rst = 1'b0; opCode = '0; funct = '0; zero = 0; mem_ready = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            opCode = 6'($urandom); funct = 6'($urandom);
            zero = 1'($urandom); mem_ready = 1'($urandom);
            #1;
            ob = observed();
            total++;
            if (state_dbg !== 4'd0 || ob !== '0) begin
                bad++;
                $display("FAIL reset_hold state=%0d outs=%h want state=0 outs=0", state_dbg, ob);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        ob = observed();
        total++;
        if (state_dbg !== 4'd0 || ob !== '0) begin
            bad++;
            $display("FAIL reset_release state=%0d outs=%h want state=0 outs=0", state_dbg, ob);
        end
    endtask

    task automatic test_r_add();
        int d;
        build(6'h00, 6'h20, 1'b0, 0, 0);
        play("r_add", d);
        total++;
        if (d !== 4) begin bad++; $display("FAIL r_add_latency got=%0d want=4", d); end
    endtask

    task automatic test_lw_stall();
        int d;
        build(6'h23, 6'h11, 1'b1, 2, 2);
        play("lw_stall", d);
        total++;
        if (d !== 9) begin bad++; $display("FAIL lw_latency got=%0d want=9", d); end
    endtask

    task automatic test_branch();
        int d;
        build(6'h04, 6'h00, 1'b1, 0, 0); play("beq_z1", d);
        build(6'h05, 6'h00, 1'b1, 0, 0); play("bne_z1", d);
        build(6'h05, 6'h00, 1'b0, 0, 0); play("bne_z0", d);
        total++;
        if (d !== 3) begin bad++; $display("FAIL branch_latency got=%0d want=3", d); end
        build(6'h02, 6'h15, 1'b0, 1, 0); play("jump", d);
    endtask

    task automatic test_itype();
        int d;
        build(6'h0C, 6'h3F, 1'b0, 0, 0); play("andi", d);
        build(6'h0A, 6'h20, 1'b1, 0, 0); play("slti", d);
        build(6'h2B, 6'h00, 1'b0, 0, 1); play("sw", d);
        total++;
        if (d !== 5) begin bad++; $display("FAIL sw_latency got=%0d want=5", d); end
    endtask

    task automatic test_illegal();
        int d;
        build(6'h3F, 6'h20, 1'b0, 0, 0); play("ill_op", d);
        total++;
        if (d !== 2) begin bad++; $display("FAIL ill_latency got=%0d want=2", d); end
        build(6'h00, 6'h00, 1'b0, 0, 0); play("ill_fn", d);
    endtask

    task automatic test_random();
        logic [5:0] ops[12] = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
                                6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h00};
        logic [5:0] fns[8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h26, 6'h00};
        logic [5:0] op, fn;
        int d;
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
            build(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
            play("random", d);
        end
    endtask

    task automatic test_mid_reset();
        int d;
        build(6'h2B, 6'h00, 1'b0, 0, 3);
        repeat (3) void'(q.pop_back());   // stop after the first MEM_WR stall cycle
        play("sw_pre_reset", d);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        total++;
        if (state_dbg !== 4'd7 || mem_write_en !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_wr state=%0d mwr=%b want state=7 mwr=1", state_dbg, mem_write_en);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (state_dbg !== 4'd0 || mem_write_en !== 1'b0 || observed() !== '0) begin
            bad++;
            $display("FAIL mid_reset_idle state=%0d mwr=%b want state=0 mwr=0", state_dbg, mem_write_en);
        end
        @(negedge clk);
        #1;
        total++;
        if (state_dbg !== 4'd1) begin
            bad++;
            $display("FAIL mid_reset_fetch state=%0d want=1", state_dbg);
        end
    endtask

    initial begin
        test_reset();
        test_r_add();
        test_lw_stall();
        test_branch();
        test_itype();
        test_illegal();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle successor to the single-cycle control unit. A Moore FSM sequences each MIPS instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives datapath enables cycle by cycle. It adds the following over the single-cycle unit:
- a memory-ready handshake
- bne, j, andi, ori, slti, xori
- nor/xor R-types
- illegal-instruction flagging

It sits between the instruction register and the shared multi-cycle datapath (PC, IR, register file, ALU, unified memory).

Parameters:
- ALUOP_W, 4, width of alu_op; must be >= 3; codes are zero-extended.
- MEM_HANDSHAKE, 1, when 1 memory states wait for mem_ready; when 0 mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- opCode  in  6  IR[31:26], valid from the cycle after FETCH completes
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC load enable
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- ir_write  out  1  IR load enable
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read_en  out  1  memory read
- mem_write_en  out  1  memory write
- reg_write_en  out  1  register file write
- reg_dst  out  1  1 rd, 0 rt
- mem_to_reg  out  1  1 MDR, 0 ALUOut
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 extended imm, 11 sign-ext imm<<2
- ext_zero  out  1  1 zero-extend immediate (andi/ori/xori)
- alu_op  out  ALUOP_W  operation code
- illegal  out  1  one-cycle pulse on undefined opcode/funct
- instr_done  out  1  one-cycle pulse in an instruction's final state
- state_dbg  out  4  current state encoding

Behaviour:
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, SLT 4, NOR 5, XOR 6.
- Funct map: add 20h, sub 22h, and 24h, or 25h, slt 2Ah, nor 27h, xor 26h.
- Opcode map: R 00h, addi 08h, slti 0Ah, andi 0Ch, ori 0Dh, xori 0Eh, lw 23h, sw 2Bh, beq 04h, bne 05h, j 02h.
- All outputs are decoded purely from state plus opCode/funct/zero/mem_ready. Any output not listed for a state is 0.
- States and encodings: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, MEM_ADDR 5, MEM_RD 6, MEM_WR 7, WB_R 8, WB_I 9, WB_MEM 10, BRANCH 11, JUMP 12.
- Reset: rst low at a clock edge puts the FSM in IDLE, including mid-instruction. In IDLE every output is 0 and state_dbg=0. IDLE goes to FETCH on the next edge.
- FETCH:
  - Outputs: mem_read_en=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, next state DECODE.
  - When mem_ready=0: stay in FETCH, no writes.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=ADD (precomputes branch target).
  - Next state: R -> EXEC_R; I-ALU -> EXEC_I; lw/sw -> MEM_ADDR; beq/bne -> BRANCH; j -> JUMP.
  - Undefined opcode, or R-type with undefined funct: illegal=1, instr_done=1, next state FETCH, no architectural write.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from funct; next WB_R.
- EXEC_I:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op per opcode.
  - ext_zero=1 for andi/ori/xori.
  - Next state WB_I.
- WB_R: reg_write_en=1, reg_dst=1, mem_to_reg=0, alu_op held, instr_done=1; next FETCH.
- WB_I: reg_write_en=1, reg_dst=0, mem_to_reg=0, instr_done=1; next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD; lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: i_or_d=1, mem_read_en=1; stall until mem_ready, then WB_MEM.
- MEM_WR:
  - Outputs: i_or_d=1, mem_write_en=1 for every cycle the state is held.
  - Stall until mem_ready.
  - On mem_ready: instr_done=1, next FETCH.
- WB_MEM: reg_write_en=1, reg_dst=0, mem_to_reg=1, instr_done=1; next FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01, instr_done=1.
  - pc_write = zero XOR (opCode==bne).
  - Next FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1; next FETCH.
- Latency in cycles, zero-wait memory: R/I-ALU 4, lw 5, sw 4, beq/bne/j 3, illegal 2. Each mem_ready=0 cycle adds one.
- opCode/funct must remain stable from DECODE through instruction end; the IR is written only in FETCH.
- Unused state encodings 13–15 go to IDLE on the next edge.

Decomposition:
- Shared package cu_pkg holds:
  - opcode and funct localparams
  - ALU op codes
  - state encoding constants
  - alu_src_b and pc_src codes
- One combinational sub-module, cu_alu_decode: inputs opCode and funct; outputs alu_op, ext_zero, legal. It is used by both DECODE (legality) and the EXEC states.

Test Plan:
- Reset, then rst held high; opCode=00h, funct=20h, mem_ready=1 -> state sequence 0,1,2,3,8,1. reg_write_en=1 with reg_dst=1 only in WB_R; instr_done pulses once.
- lw (23h) with mem_ready low for 2 cycles in both FETCH and MEM_RD -> 9 cycles FETCH-to-WB_MEM exit. ir_write and pc_write assert only on the mem_ready cycle; mem_to_reg=1 in WB_MEM.
- beq with zero=1 -> pc_write=1 and pc_src=01 in BRANCH. bne with zero=1 -> pc_write=0. bne with zero=0 -> pc_write=1.
- andi (0Ch) -> EXEC_I with ext_zero=1, alu_op=2. slti (0Ah) -> alu_op=4, ext_zero=0.
- opCode=3Fh, and separately R-type with funct=00h -> illegal pulses one cycle in DECODE, no reg_write_en or mem_write_en, then FETCH.
- rst low during MEM_WR -> next cycle state 0 with mem_write_en=0. Releasing rst -> FETCH one cycle later.
